// File: rtl/prod_accum.sv
// prod_accum: sums frames of N signed products into a signed ACC_W-bit
// running accumulator and presents each completed frame sum, together with a
// sticky signed-overflow flag, on an output handshake.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both high. A valid source holds its data stable
// until the transfer, and ready never depends on the same-side valid. Here
// in_ready is a pure function of the FSM state, and out_valid/acc_out/ovf are
// registered, so the sink can never see them glitch.
module prod_accum #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12,
  parameter int N      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_prod,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic                     ovf,
  output logic [$clog2(N+1)-1:0]   beat_cnt
);

  localparam int CNT_W = $clog2(N + 1);

  // IDLE: empty frame, waiting for the first beat.
  // ACCUM: frame in progress, 1..N-1 beats taken.
  // DONE: N beats taken, result offered downstream, input side stalled.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // state is kept as a named signal so checkers can bind to it directly.
  state_t                    state;
  state_t                    state_nxt;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_nxt;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   sum;
  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          cnt_nxt;
  logic [CNT_W-1:0]          cnt_inc;
  logic                      ovf_r;
  logic                      ovf_nxt;
  logic                      add_ovf;
  logic                      accept;
  logic                      handoff;
  logic                      last_beat;

  // Datapath: sign-extend the product and form the wrapping sum. Signed
  // overflow is the classic rule: equal operand signs, different result sign.
  assign prod_ext  = ACC_W'(in_prod);
  assign sum       = acc + prod_ext;
  assign add_ovf   = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                     (sum[ACC_W-1] != acc[ACC_W-1]);
  assign cnt_inc   = cnt + CNT_W'(1);
  assign last_beat = (cnt_inc == CNT_W'(N));

  // Handshake qualifiers. in_ready depends on state only.
  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign handoff   = out_valid && out_ready;

  assign acc_out   = acc;
  assign ovf       = ovf_r;
  assign beat_cnt  = cnt;

  // State and datapath registers; async reset returns to an empty frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf_r <= ovf_nxt;
    end
  end

  // Next-state and datapath update. clr has priority over any accept or
  // handoff in the same cycle, so a beat arriving with clr is dropped and a
  // result being handed off with clr is discarded.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf_r;

    if (clr) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // First beat loads rather than adds, which also clears the
          // overflow flag at frame start.
          if (accept) begin
            acc_nxt   = prod_ext;
            cnt_nxt   = CNT_W'(1);
            ovf_nxt   = 1'b0;
            state_nxt = (CNT_W'(N) == CNT_W'(1)) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_nxt = sum;
            cnt_nxt = cnt_inc;
            ovf_nxt = ovf_r | add_ovf;
            if (last_beat) begin
              state_nxt = DONE;
            end
          end
        end
        DONE: begin
          // Result held until taken; the new frame starts from zero.
          if (handoff) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
          end
        end
        default: begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      endcase
    end
  end

  // Structural invariants of the frame counter and the DONE hold behaviour.
  a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
    cnt <= CNT_W'(N));

  a_done_hold: assert property (@(posedge clk) disable iff (rst)
    (state == DONE && !out_ready && !clr) |=>
      (state == DONE && $stable(acc) && $stable(cnt) && $stable(ovf_r)));

  a_idle_empty: assert property (@(posedge clk) disable iff (rst)
    (state == IDLE) |-> (acc == '0 && cnt == '0 && !ovf_r));

endmodule

// File: tb/tb_prod_accum.sv
// Bench for prod_accum: two instances (ACC_W=12 and ACC_W=9) share one input
// stream. A frame-level model (list of accepted beats) predicts every output
// each cycle; directed scenarios add hand-computed literal expectations.
module tb_prod_accum;

  localparam int N = 4;

  logic              clk;
  logic              rst;
  logic              clr;
  logic              in_valid;
  logic [7:0]        in_prod;
  logic              out_ready;

  logic              in_ready_a, out_valid_a, ovf_a;
  logic [11:0]       acc_a;
  logic [2:0]        cnt_a;
  logic              in_ready_b, out_valid_b, ovf_b;
  logic [8:0]        acc_b;
  logic [2:0]        cnt_b;

  int checks = 0;
  int errors = 0;

  prod_accum #(.PROD_W(8), .ACC_W(12), .N(N)) u_dut_a (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_prod(in_prod),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .acc_out(acc_a), .ovf(ovf_a), .beat_cnt(cnt_a)
  );

  prod_accum #(.PROD_W(8), .ACC_W(9), .N(N)) u_dut_b (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_prod(in_prod),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .acc_out(acc_b), .ovf(ovf_b), .beat_cnt(cnt_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  // ---------------- model ----------------
  // The frame is just the list of products accepted so far; the outputs
  // follow from it: full list means result offered, sum wraps to width.
  int beats[$];

  function automatic int wrapw(int v, int w);
    int m;
    int r;
    m = 1 << w;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic void fold(int w, output int s, output bit o);
    int t;
    s = 0;
    o = 1'b0;
    foreach (beats[i]) begin
      if (i == 0) begin
        s = wrapw(beats[i], w);
      end else begin
        t = s + beats[i];
        if (t > (1 << (w - 1)) - 1 || t < -(1 << (w - 1))) o = 1'b1;
        s = wrapw(t, w);
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      beats.delete();
    end else if (clr) begin
      beats.delete();
    end else if (beats.size() != N && in_valid) begin
      beats.push_back(int'($signed(in_prod)));
    end else if (beats.size() == N && out_ready) begin
      beats.delete();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  bit started = 1'b0;

  always @(negedge clk) begin
    int  s12, s9, sz;
    bit  o12, o9;
    if (started && !rst) begin
      fold(12, s12, o12);
      fold(9, s9, o9);
      sz = beats.size();
      check("cyc in_ready_a",  int'(in_ready_a),  int'(sz != N));
      check("cyc in_ready_b",  int'(in_ready_b),  int'(sz != N));
      check("cyc out_valid_a", int'(out_valid_a), int'(sz == N));
      check("cyc out_valid_b", int'(out_valid_b), int'(sz == N));
      check("cyc beat_cnt_a",  int'(cnt_a), sz);
      check("cyc beat_cnt_b",  int'(cnt_b), sz);
      check("cyc acc_a",       int'($signed(acc_a)), s12);
      check("cyc acc_b",       int'($signed(acc_b)), s9);
      check("cyc ovf_a",       int'(ovf_a), int'(o12));
      check("cyc ovf_b",       int'(ovf_b), int'(o9));
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_beat(input int p);
    in_valid = 1'b1;
    in_prod  = 8'(p);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int p0, input int p1, input int p2, input int p3);
    send_beat(p0);
    send_beat(p1);
    send_beat(p2);
    send_beat(p3);
  endtask

  task automatic expect_result(input string tag, input int ea, input int oa,
                               input int eb, input int ob);
    check({tag, " out_valid"}, int'(out_valid_a & out_valid_b), 1);
    check({tag, " acc_a"}, int'($signed(acc_a)), ea);
    check({tag, " ovf_a"}, int'(ovf_a), oa);
    check({tag, " acc_b"}, int'($signed(acc_b)), eb);
    check({tag, " ovf_b"}, int'(ovf_b), ob);
    check({tag, " beat_cnt"}, int'(cnt_a), N);
  endtask

  task automatic expect_empty(input string tag);
    check({tag, " out_valid"}, int'(out_valid_a | out_valid_b), 0);
    check({tag, " acc_a"}, int'(acc_a), 0);
    check({tag, " acc_b"}, int'(acc_b), 0);
    check({tag, " ovf"}, int'(ovf_a | ovf_b), 0);
    check({tag, " beat_cnt"}, int'(cnt_a | cnt_b), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    out_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    started = 1'b1;
    expect_empty("reset");
    check("reset in_ready", int'(in_ready_a & in_ready_b), 1);

    // Back-to-back frame, result one cycle after the 4th beat, IDLE after.
    send_frame(21, -10, 15, 64);
    expect_result("basic", 90, 0, 90, 0);
    tick();
    expect_empty("basic handoff");

    // Wrap and overflow in the 9-bit instance, none in the 12-bit one.
    out_ready = 1'b0;
    send_frame(127, 127, 127, 127);
    expect_result("wrap", 508, 0, -4, 1);
    idle(2);
    expect_result("wrap hold", 508, 0, -4, 1);
    out_ready = 1'b1;
    tick();
    expect_empty("wrap handoff");
    send_frame(1, 1, 1, 1);
    expect_result("after wrap", 4, 0, 4, 0);
    tick();

    // Output stall with in_valid held high: nothing consumed.
    out_ready = 1'b0;
    send_frame(1, 2, 3, 4);
    in_valid = 1'b1;
    in_prod  = 8'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall in_ready", int'(in_ready_a | in_ready_b), 0);
      expect_result("stall", 10, 0, 10, 0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    expect_empty("stall handoff");

    // clr together with a beat drops the beat.
    send_beat(5);
    send_beat(6);
    check("pre clr acc", int'($signed(acc_a)), 11);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_prod  = 8'd7;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    expect_empty("clr beat");
    send_frame(1, 1, 1, 1);
    expect_result("after clr", 4, 0, 4, 0);
    tick();

    // clr while a result is waiting discards it.
    out_ready = 1'b0;
    send_frame(2, 2, 2, 2);
    expect_result("pre clr done", 8, 0, 8, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    out_ready = 1'b1;
    expect_empty("clr done");

    // Async reset in DONE with the overflow flag set.
    out_ready = 1'b0;
    send_frame(127, 127, 127, 127);
    expect_result("pre rst", 508, 0, -4, 1);
    #2;
    rst = 1'b1;
    #1;
    expect_empty("async rst done");
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    check("rst in_ready", int'(in_ready_a & in_ready_b), 1);

    // Async reset mid-frame, then negative frame with and without gaps.
    send_beat(5);
    send_beat(3);
    #2;
    rst = 1'b1;
    #1;
    expect_empty("async rst accum");
    tick();
    rst = 1'b0;
    send_frame(-8, -8, -8, -8);
    expect_result("neg", -32, 0, -32, 0);
    tick();
    send_beat(-8);
    idle(2);
    check("gap hold cnt", int'(cnt_a), 1);
    send_beat(-8);
    idle(1);
    send_beat(-8);
    idle(3);
    check("gap hold acc", int'($signed(acc_b)), -24);
    send_beat(-8);
    expect_result("neg gaps", -32, 0, -32, 0);
    tick();
    expect_empty("neg gaps handoff");

    // Most negative 9-bit result is legal: -128 -128 +1 -1 = -256.
    send_frame(-128, -128, 1, -1);
    expect_result("min", -256, 0, -256, 0);
    tick();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
